// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the riscv_lsu load/store unit: funct3 encodings,
// FSM states, strobe constants and access-size/lane helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  // Undefined encodings (011, 110, 111) behave as a word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Byte lane after discarding address bits below the access size.
  function automatic logic [1:0] eff_lane(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_B:    return lo;
      SZ_H:    return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data replication and byte strobes,
// plus load byte/half extraction with sign or zero extension.
module lsu_lane_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data
);

  lsu_size_e   size;
  logic [1:0]  lane;
  logic        sext;
  logic [31:0] shifted;

  always_comb begin
    size      = f3_size(funct3);
    lane      = eff_lane(funct3, addr_lo);
    sext      = ~funct3[2];
    shifted   = mem_rdata >> {lane, 3'b000};
    mem_wdata = st_data;
    mem_wstrb = STRB_W;
    ld_data   = shifted;
    case (size)
      SZ_B: begin
        mem_wdata = {4{st_data[7:0]}};
        mem_wstrb = STRB_B << lane;
        ld_data   = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        mem_wdata = {2{st_data[15:0]}};
        mem_wstrb = STRB_H << lane;
        ld_data   = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one CPU access -> one valid/ready word memory transaction.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and flag misalign_err.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              misalign_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              capture;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        f3_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_strb;
  logic [DATA_W-1:0] ld_data;
  logic              go_done;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign go_done = is_misaligned(req_funct3, req_addr[1:0]);
`else
  assign go_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    mem_req = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = go_done ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (capture) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q   <= go_done;
`endif
      end
      if (state_q == ACCESS && mem_ready && !we_q) rdata_q <= ld_data;
    end
  end

  lsu_lane_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .st_data   (wdata_q),
    .mem_wdata (st_data),
    .mem_wstrb (st_strb),
    .mem_rdata (mem_rdata),
    .ld_data   (ld_data)
  );

  assign mem_we    = mem_req & we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = st_data;
  assign mem_wstrb = (mem_req && we_q) ? st_strb : '0;
  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_err = (state_q == DONE) & mis_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: directed accesses, memory-side and
// response-side monitors comparing against hand-computed expectations.
module tb_riscv_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        stall, rsp_valid, misalign_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int errors = 0;
  int checks = 0;
  int wait_n = 0;
  int wcnt   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        mis;
  } rsp_exp_t;

  mem_exp_t mem_q[$];
  rsp_exp_t rsp_q[$];

  riscv_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_funct3   (req_funct3),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .misalign_err (misalign_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: holds mem_ready low for wait_n request cycles, then accepts.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && !reset) begin
        if (wcnt >= wait_n) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Memory-side monitor: every request cycle must match the pending expectation.
  initial begin
    mem_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", {31'b0, mem_req}, 32'd0);
        end else begin
          e = mem_q[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, e.strb});
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          if (mem_ready) void'(mem_q.pop_front());
        end
      end
    end
  end

  // Response-side monitor.
  initial begin
    rsp_exp_t r;
    forever begin
      @(negedge clk);
      #1;
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          if (r.chk_rdata) chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("misalign_err", {31'b0, misalign_err}, {31'b0, r.mis});
        end
      end else if (misalign_err) begin
        chk("misalign_err_idle", {31'b0, misalign_err}, 32'd0);
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int wn, input logic [31:0] word,
                        input bit mem_exp, input logic [31:0] e_addr, input logic [3:0] e_strb,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                        input bit e_mis, input int e_stall, input string name);
    mem_exp_t m;
    rsp_exp_t r;
    int n;
    bit seen;
    if (mem_exp) begin
      m.we = we; m.addr = e_addr; m.strb = e_strb; m.wdata = e_wdata;
      mem_q.push_back(m);
    end
    r.chk_rdata = !we || e_mis;
    r.rdata = e_rdata;
    r.mis = e_mis;
    rsp_q.push_back(r);
    wait_n = wn;
    mem_rdata = word;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    n = 0;
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (stall) n++;
      if (rsp_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_stall_cycles"}, n, e_stall);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_single_rsp"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_misalign_err"}, {31'b0, misalign_err}, 32'd0);
    chk({tag, "_stall"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    //      we  addr          wdata         f3      wn word          mem  e_addr        strb     e_wdata       e_rdata       mis stall
    access(1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 32'h0,        1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        0, 2, "sw");
    access(1, 32'h103, 32'h000000AB, 3'b000, 0, 32'h0,        1, 32'h100, 4'b1000, 32'hABABABAB, 32'h0,        0, 2, "sb");
    access(1, 32'h102, 32'h12345678, 3'b001, 1, 32'h0,        1, 32'h100, 4'b1100, 32'h56785678, 32'h0,        0, 3, "sh");
    access(0, 32'h202, 32'h0,        3'b000, 0, 32'h12F03456, 1, 32'h200, 4'b0000, 32'h0,        32'hFFFFFFF0, 0, 2, "lb");
    access(0, 32'h202, 32'h0,        3'b100, 0, 32'h12F03456, 1, 32'h200, 4'b0000, 32'h0,        32'h000000F0, 0, 2, "lbu");
    access(0, 32'h202, 32'h0,        3'b101, 0, 32'h12F03456, 1, 32'h200, 4'b0000, 32'h0,        32'h000012F0, 0, 2, "lhu");
    access(0, 32'h200, 32'h0,        3'b001, 2, 32'h00008001, 1, 32'h200, 4'b0000, 32'h0,        32'hFFFF8001, 0, 4, "lh");
    access(0, 32'h201, 32'h0,        3'b000, 0, 32'h00008000, 1, 32'h200, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 2, "lb1");
    access(0, 32'h204, 32'h0,        3'b010, 4, 32'hCAFEF00D, 1, 32'h204, 4'b0000, 32'h0,        32'hCAFEF00D, 0, 6, "lw_wait");
    access(0, 32'h208, 32'h0,        3'b011, 0, 32'h87654321, 1, 32'h208, 4'b0000, 32'h0,        32'h87654321, 0, 2, "undef_f3");

    if (TRAP) begin
      access(0, 32'h101, 32'h0,        3'b001, 0, 32'hAAAAB7C3, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1, "lh_mis");
      access(1, 32'h101, 32'h11223344, 3'b010, 0, 32'h0,        0, 32'h0,   4'b0000, 32'h0,        32'h0,        1, 1, "sw_mis");
    end else begin
      access(0, 32'h101, 32'h0,        3'b001, 0, 32'hAAAAB7C3, 1, 32'h100, 4'b0000, 32'h0,        32'hFFFFB7C3, 0, 2, "lh_mis");
      access(1, 32'h101, 32'h11223344, 3'b010, 0, 32'h0,        1, 32'h100, 4'b1111, 32'h11223344, 32'h0,        0, 2, "sw_mis");
    end

    // Reset while the memory is still withholding mem_ready.
    wait_n = 20;
    mem_q.push_back('{we: 1'b0, addr: 32'h300, strb: 4'b0000, wdata: 32'h0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_funct3 = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_access", {31'b0, mem_req}, 32'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    mem_q.delete();
    @(negedge clk);
    chk_idle_zero("abort");
    @(posedge clk); #1;
    reset = 1'b0;
    access(1, 32'h104, 32'h0BADF00D, 3'b010, 0, 32'h0, 1, 32'h104, 4'b1111, 32'h0BADF00D, 32'h0, 0, 2, "sw_after_abort");

    repeat (3) @(posedge clk);
    chk("mem_q_drained", mem_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
